// File: rtl/j1_irq_ctrl_if.sv
// IO bus between the j1 core and the interrupt controller.
// The core drives strobes, address and write data; the controller returns read data.
interface j1_irq_ctrl_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  modport master (
    output io_rd,
    output io_wr,
    output io_addr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_rd,
    input  io_wr,
    input  io_addr,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/j1_irq_ctrl.sv
// Interrupt controller plus Timer1 for the j1 core.
// Seven external sources are synchronised and edge detected, and a 16-bit
// reload timer provides source 7. All of them latch into a pending register,
// which is masked and registered onto int_rqst.
module j1_irq_ctrl #(
  parameter logic [15:0] BASE     = 16'h0100,
  parameter int unsigned PRESCALE = 16
) (
  input  logic               clk,
  input  logic               resetq,
  j1_irq_ctrl_if.slave       bus,
  input  logic [6:0]         irq_src,
  output logic [7:0]         int_rqst
);

  localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [15:0] A_PEND   = BASE;
  localparam logic [15:0] A_MASK   = BASE + 16'd1;
  localparam logic [15:0] A_RELOAD = BASE + 16'd2;
  localparam logic [15:0] A_COUNT  = BASE + 16'd3;
  localparam logic [15:0] A_TCTL   = BASE + 16'd4;

  // Source conditioning state
  logic [6:0]    sync1_q, sync2_q, sync3_q;
  logic [2:0]    arm_q;
  logic [6:0]    src_rise;

  // Architectural registers
  logic [7:0]    pend_q, pend_d;
  logic [7:0]    mask_q, mask_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   count_q, count_d;
  logic          run_q, run_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    int_rqst_q;

  logic          wr_pend, wr_mask, wr_reload, wr_tctl;
  logic          tick, timer_fire;

  assign wr_pend   = bus.io_wr && (bus.io_addr == A_PEND);
  assign wr_mask   = bus.io_wr && (bus.io_addr == A_MASK);
  assign wr_reload = bus.io_wr && (bus.io_addr == A_RELOAD);
  assign wr_tctl   = bus.io_wr && (bus.io_addr == A_TCTL);

  // arm_q[2] marks that sync3 holds a genuine sample rather than its reset
  // value, so a level already high when reset lifts is not taken as an edge.
  assign src_rise = sync2_q & ~sync3_q & {7{arm_q[2]}};

  // Two-flop synchroniser, edge-detect history and post-reset arming
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      arm_q   <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      arm_q   <= {arm_q[1:0], 1'b1};
    end
  end

  // Timer1: prescaler, down-counter with reload; a RELOAD write overrides a tick
  always_comb begin
    presc_d    = presc_q;
    count_d    = count_q;
    tick       = 1'b0;
    timer_fire = 1'b0;
    if (run_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end
    if (tick) begin
      if (count_q == 16'd0) begin
        count_d    = reload_q;
        timer_fire = 1'b1;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
    if (wr_reload) begin
      count_d    = bus.io_wdata;
      presc_d    = '0;
      timer_fire = 1'b0;
    end
  end

  // Register file next state; new events are OR-ed after the W1C so set wins
  always_comb begin
    pend_d   = pend_q;
    mask_d   = mask_q;
    reload_d = reload_q;
    run_d    = run_q;
    if (wr_pend)   pend_d   = pend_q & ~bus.io_wdata[7:0];
    pend_d = pend_d | {timer_fire, src_rise};
    if (wr_mask)   mask_d   = bus.io_wdata[7:0];
    if (wr_reload) reload_d = bus.io_wdata;
    if (wr_tctl)   run_d    = bus.io_wdata[0];
  end

  // State registers and the masked request output
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pend_q     <= '0;
      mask_q     <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      run_q      <= 1'b0;
      presc_q    <= '0;
      int_rqst_q <= '0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      run_q      <= run_d;
      presc_q    <= presc_d;
      int_rqst_q <= pend_q & mask_q;
    end
  end

  assign int_rqst = int_rqst_q;

  // Combinational read mux; zero when idle so it can be OR-ed into io_din
  always_comb begin
    bus.io_rdata = 16'h0000;
    if (bus.io_rd) begin
      case (bus.io_addr)
        A_PEND:   bus.io_rdata = {8'h00, pend_q};
        A_MASK:   bus.io_rdata = {8'h00, mask_q};
        A_RELOAD: bus.io_rdata = reload_q;
        A_COUNT:  bus.io_rdata = count_q;
        A_TCTL:   bus.io_rdata = {15'h0000, run_q};
        default:  bus.io_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_irq_ctrl.sv
// Directed and randomised checks of j1_irq_ctrl against a behavioural model.
module tb_j1_irq_ctrl;
  localparam logic [15:0] BASE = 16'h0100;
  localparam int          P    = 16;

  logic       clk = 1'b0;
  logic       resetq;
  logic [6:0] irq_src;
  logic [7:0] int_rqst;

  j1_irq_ctrl_if bus();

  j1_irq_ctrl #(.BASE(BASE), .PRESCALE(P)) dut (
    .clk      (clk),
    .resetq   (resetq),
    .bus      (bus.slave),
    .irq_src  (irq_src),
    .int_rqst (int_rqst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start at a negedge and return at a later negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.io_wr    = 1'b1;
    bus.io_addr  = a;
    bus.io_wdata = d;
    @(negedge clk);
    bus.io_wr    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.io_rd   = 1'b1;
    bus.io_addr = a;
    #1 d = bus.io_rdata;
    bus.io_rd   = 1'b0;
    @(negedge clk);
  endtask

  // Timer model: n running edges since start give n/P ticks; the counter
  // cycles r, r-1, ..., 0 and fires when a tick lands on 0.
  function automatic logic [15:0] mcount(input int n, input int r);
    int k;
    k = n / P;
    return 16'(r - (k % (r + 1)));
  endfunction

  function automatic logic mfired(input int n, input int r);
    return ((n / P) / (r + 1)) > 0;
  endfunction

  initial begin
    logic [15:0] d;
    logic [15:0] frozen;
    logic [7:0]  m_pend, m_mask, clr;
    logic [6:0]  v, m_prev;
    int          t0, r, n, len;

    bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;
    irq_src = 7'h7F;
    resetq  = 1'b0;

    // 1: reset with sources high, then a clean edge on bit 3
    @(negedge clk); @(negedge clk);
    check("rst_int_rqst", 16'(int_rqst), 16'h0000);
    rd(BASE, d); check("rst_pend", d, 16'h0000);
    resetq = 1'b1;
    idle(6);
    rd(BASE, d); check("held_level_no_edge", d, 16'h0000);
    wr(BASE + 16'd1, 16'h0008);
    irq_src = 7'h77; idle(3);
    irq_src = 7'h7F;
    idle(3); check("latency_edge3", 16'(int_rqst), 16'h0000);
    idle(1); check("latency_edge4", 16'(int_rqst), 16'h0008);
    rd(BASE, d); check("pend_bit3", d, 16'h0008);
    wr(BASE, 16'h0008);
    rd(BASE, d); check("pend_bit3_cleared", d, 16'h0000);
    irq_src = 7'h00; idle(4);

    // 2: masked source still latches; unmask raises; W1C drops
    wr(BASE + 16'd1, 16'h0000);
    irq_src[0] = 1'b1; idle(2); irq_src[0] = 1'b0; idle(5);
    check("masked_int", 16'(int_rqst), 16'h0000);
    rd(BASE, d); check("masked_pend", d, 16'h0001);
    wr(BASE + 16'd1, 16'h0001);
    check("unmask_same", 16'(int_rqst), 16'h0000);
    idle(1); check("unmask_next", 16'(int_rqst), 16'h0001);
    wr(BASE, 16'h0001);
    check("w1c_same", 16'(int_rqst), 16'h0001);
    idle(1); check("w1c_next", 16'(int_rqst), 16'h0000);

    // Randomised source activity against the edge-latching model
    m_prev = irq_src; m_pend = 8'h00;
    for (int it = 0; it < 12; it++) begin
      m_mask = 8'($urandom);
      wr(BASE + 16'd1, 16'(m_mask));
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) begin
        v = 7'($urandom);
        irq_src = v;
        m_pend[6:0] = m_pend[6:0] | (v & ~m_prev);
        m_prev = v;
        idle(1);
      end
      idle(4);
      rd(BASE, d); check("rand_pend", d, 16'(m_pend));
      check("rand_int", 16'(int_rqst), 16'(m_pend & m_mask));
      clr = 8'($urandom);
      wr(BASE, 16'(clr));
      m_pend = m_pend & ~clr;
    end
    irq_src = 7'h00; idle(3);
    wr(BASE, 16'h00FF);

    // 3: timer with RELOAD=4
    wr(BASE + 16'd1, 16'h0080);
    r = 4;
    wr(BASE + 16'd2, 16'(r));
    wr(BASE + 16'd4, 16'h0001);
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      idle_to(t0 + 8 + 16 * k);
      n = cyc - t0;
      rd(BASE + 16'd3, d); check("count_step", d, mcount(n, r));
    end
    idle_to(t0 + 79);
    rd(BASE, d); check("no_fire_79", d, 16'h0000);
    rd(BASE, d); check("fire_80", d, 16'h0080);
    check("int_after_fire", 16'(int_rqst), 16'h0080);
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(1, 40));
      n = cyc - t0;
      rd(BASE + 16'd3, d); check("rand_count", d, mcount(n, r));
    end
    wr(BASE + 16'd4, 16'h0000);
    frozen = mcount(cyc - t0, r);
    idle(40);
    rd(BASE + 16'd3, d); check("count_frozen", d, frozen);

    // Randomised reload values
    for (int it = 0; it < 3; it++) begin
      r = $urandom_range(0, 5);
      wr(BASE + 16'd2, 16'(r));
      wr(BASE, 16'h0080);
      wr(BASE + 16'd4, 16'h0001);
      t0 = cyc;
      for (int k = 0; k < 5; k++) begin
        idle($urandom_range(1, 50));
        n = cyc - t0;
        rd(BASE + 16'd3, d); check("rand_reload_count", d, mcount(n, r));
        n = cyc - t0;
        rd(BASE, d); check("rand_reload_pend", d, mfired(n, r) ? 16'h0080 : 16'h0000);
      end
      wr(BASE + 16'd4, 16'h0000);
    end

    // 4a: W1C of bit 7 on the very edge the timer fires
    wr(BASE + 16'd2, 16'd4);
    wr(BASE, 16'h0080);
    wr(BASE + 16'd4, 16'h0001);
    t0 = cyc;
    idle_to(t0 + 79);
    wr(BASE, 16'h0080);
    rd(BASE, d); check("set_beats_clear", d, 16'h0080);
    wr(BASE, 16'h0080);
    rd(BASE, d); check("clear_after", d, 16'h0000);

    // 4b: RELOAD write on a firing tick
    wr(BASE + 16'd4, 16'h0000);
    wr(BASE + 16'd2, 16'h0000);
    wr(BASE, 16'h0080);
    wr(BASE + 16'd4, 16'h0001);
    t0 = cyc;
    idle_to(t0 + 15);
    wr(BASE + 16'd2, 16'h0010);
    rd(BASE + 16'd3, d); check("reload_wins_count", d, 16'h0010);
    rd(BASE, d); check("reload_wins_pend", d, 16'h0000);
    wr(BASE + 16'd4, 16'h0000);

    // 5: decode boundaries and read-only COUNT
    wr(BASE + 16'd1, 16'h00A5);
    rd(BASE + 16'd5, d); check("rd_base_plus5", d, 16'h0000);
    rd(BASE - 16'd1, d); check("rd_base_minus1", d, 16'h0000);
    bus.io_addr = BASE + 16'd1;
    #1 check("rd_strobe_low", bus.io_rdata, 16'h0000);
    rd(BASE + 16'd1, d); check("rd_mask", d, 16'h00A5);
    rd(BASE + 16'd2, d); check("rd_reload", d, 16'h0010);
    rd(BASE + 16'd4, d); check("rd_tctl", d, 16'h0000);
    wr(BASE + 16'd3, 16'h1234);
    rd(BASE + 16'd3, d); check("count_readonly", d, 16'h0010);
    for (int it = 0; it < 4; it++) begin
      m_mask = 8'($urandom);
      wr(BASE + 16'd1, {8'($urandom), m_mask});
      rd(BASE + 16'd1, d); check("rand_mask_rw", d, 16'(m_mask));
    end

    // 6: asynchronous reset with everything pending
    wr(BASE + 16'd1, 16'h00FF);
    wr(BASE + 16'd2, 16'h0001);
    wr(BASE + 16'd4, 16'h0001);
    irq_src = 7'h7F;
    idle(40);
    check("all_pending", 16'(int_rqst), 16'h00FF);
    @(posedge clk); #2;
    resetq = 1'b0;
    #1 check("async_int", 16'(int_rqst), 16'h0000);
    bus.io_rd = 1'b1; bus.io_addr = BASE;
    #1 check("async_pend", bus.io_rdata, 16'h0000);
    bus.io_addr = BASE + 16'd1;
    #1 check("async_mask", bus.io_rdata, 16'h0000);
    bus.io_addr = BASE + 16'd2;
    #1 check("async_reload", bus.io_rdata, 16'h0000);
    bus.io_rd = 1'b0;
    @(negedge clk);
    resetq = 1'b1;
    idle(6);
    rd(BASE, d); check("post_reset_pend", d, 16'h0000);
    check("post_reset_int", 16'(int_rqst), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/j1_irq_ctrl.md
Name: j1_irq_ctrl

Overview:
Interrupt controller and Timer1 that sits directly upstream of the j1 core and drives its 8-bit int_rqst input. It latches edges from 7 external sources plus an internal 16-bit reload timer (source 7, highest priority) into a pending register, masks them, and presents the result to the core. The core's ISR acknowledges sources through IO writes on the core's io_rd/io_wr/mem_addr/dout/io_din bus.

Parameters:
BASE, 16'h0100, IO address of register 0; registers occupy BASE..BASE+4.
PRESCALE, 16, clk cycles per timer tick (>=1).

Ports:
clk  in  1  system clock
resetq  in  1  asynchronous active-low reset
io_rd  in  1  core IO read strobe
io_wr  in  1  core IO write strobe
io_addr  in  16  core mem_addr (st0)
io_wdata  in  16  core dout (st1)
io_rdata  out  16  read data, OR-muxed into core io_din
irq_src  in  7  asynchronous external sources, bit i maps to int_rqst[i]
int_rqst  out  8  masked pending requests to core; bit 7 = Timer1

Behaviour:
- Reset (resetq low, async): pending=0, enable=0, reload=0, count=0, tctl=0, prescaler=0, synchronisers=0, int_rqst=0. io_rdata is combinational, so it reads 0 whenever io_rd is low.
- Source conditioning: each irq_src bit passes through a 2-FF synchroniser, then rising-edge detect (sync2 & ~sync3).
  - A detected edge sets pending[i] on the next clk edge.
  - A level held high sets pending only once.
- Registers, at offset from BASE:
  - +0 PEND: read returns pending[7:0] zero-extended. Write is write-1-to-clear on bits [7:0].
  - +1 MASK: read/write enable[7:0].
  - +2 RELOAD: read/write 16 bits. A write also loads count with io_wdata and resets the prescaler.
  - +3 COUNT: read-only current count. Writes are ignored.
  - +4 TCTL: bit0 is the run bit. Read/write.
- Register writes: a write takes effect at the clk edge where io_wr=1 and io_addr matches. Unmapped addresses and upper bits are ignored.
- Register reads:
  - io_rdata is valid combinationally in the same cycle as io_rd, because the core samples io_din in that cycle.
  - io_rdata=0 when io_rd=0 or io_addr is outside BASE..BASE+4.
  - Reads have no side effects.
- Timer:
  - When tctl[0]=1, the prescaler counts 0..PRESCALE-1 and asserts tick on wrap.
  - On tick: if count==0, then count<=reload and pending[7] is set; otherwise count<=count-1.
  - Period is (reload+1)*PRESCALE cycles. reload=0 fires on every tick.
  - Clearing tctl[0] freezes count and resets the prescaler to 0.
- Output: int_rqst <= pending & enable, registered, one cycle after pending/enable update. The core does its own priority encoding; no priority logic lives here.
- Latency: source edge at the pin to int_rqst high is 4 clk edges (sync, sync, pending, output register), provided the mask bit is set.
- Simultaneous events: set beats clear.
  - If a PEND write-1-to-clear and a new edge/tick for the same bit occur in the same cycle, pending stays 1.
  - A RELOAD write and a tick in the same cycle: the write wins (count=io_wdata, no pending set).
- Masking: a masked source still latches into pending. Unmasking later raises int_rqst from the stored pending bit.
- Reset mid-operation: everything clears immediately, including in-flight synchroniser state.

Test Plan:
1. Reset with irq_src=7'h7F held high -> int_rqst=0, PEND reads 0 after release (no edge). Drop then raise bit 3 with MASK=8'h08 -> int_rqst=8'h08 exactly 4 clk later.
2. MASK=0, pulse irq_src[0] -> int_rqst stays 0, PEND reads 16'h0001. Write MASK=8'h01 -> int_rqst=8'h01 next cycle+1. Write PEND=16'h0001 -> int_rqst=0 two cycles later.
3. PRESCALE=16, RELOAD=4, TCTL=1 -> pending[7] sets every 80 clk. COUNT reads 4,3,2,1,0 each 16 clk apart. TCTL=0 -> COUNT frozen.
4. Same cycle: PEND write 16'h0080 and timer wrap -> pending[7] remains 1. Same cycle: RELOAD write 16'h0010 and tick -> COUNT reads 16'h0010, no new pending.
5. io_rd with io_addr=BASE+5 and BASE-1 -> io_rdata=0. io_rd=0 at io_addr=BASE+1 -> io_rdata=0. Write to COUNT -> COUNT unchanged.
6. Assert resetq low mid-count with pending=8'hFF -> all outputs 0 asynchronously, before the next clk edge.
